// File: rtl/uart_tx_engine.sv
// uart_tx_engine: TX FIFO feeding a UART frame serialiser (start, 5..8 data bits, optional parity, 1..4 stop bits).
// Define UART_TX_CTS_EN to add the i_cts_n flow-control input; otherwise frames start whenever enabled.
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        i_s_axi_aclk,
  input  logic        i_s_axi_areset,
  input  logic        i_module_en,
  input  logic        i_fifo_clr,
  input  logic [31:0] i_fre_cnt,
  input  logic [3:0]  i_uart_data_bit,
  input  logic [2:0]  i_uart_parity_mode,
  input  logic [2:0]  i_uart_stop_bit,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_valid,
`ifdef UART_TX_CTS_EN
  input  logic        i_cts_n,
`endif
  output logic [15:0] o_tx_fifo_wr_cnt,
  output logic        o_tx_busy,
  output logic        o_tx_ovf,
  output logic        o_txd
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  state_t             state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               pop;
  logic               cts_ok;

  logic [31:0] div_s;
  logic [3:0]  nbits_s;
  logic [2:0]  stop_s;
  logic        par_en_s;
  logic        par_bit_s;
  logic [7:0]  head;
  logic [7:0]  mask;

  logic [31:0] div_q;
  logic [31:0] timer;
  logic [3:0]  nbits_q;
  logic [3:0]  bit_cnt;
  logic [2:0]  stop_rem;
  logic        par_en_q;
  logic        par_bit_q;
  logic [7:0]  shreg;
  logic        tick;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  always_ff @(posedge i_s_axi_aclk or posedge i_s_axi_areset) begin
    if (i_s_axi_areset) cts_sync <= 2'b11;
    else                cts_sync <= {cts_sync[0], i_cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // i_tx_valid is a write strobe with no ready: every high cycle offers one byte,
  // accepted if the FIFO was not full at the start of that cycle, otherwise dropped
  // and recorded in the sticky o_tx_ovf. i_fifo_clr overrides both write and pop.
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  assign wr_en = i_tx_valid & ~full & ~i_fifo_clr;
  assign pop   = (state == IDLE) & i_module_en & ~empty & cts_ok & ~i_fifo_clr;
  assign tick  = (timer == 32'd0);

  assign o_tx_fifo_wr_cnt = {{(15 - FIFO_AW){1'b0}}, count};

  always_ff @(posedge i_s_axi_aclk) begin
    if (wr_en) mem[wr_ptr] <= i_tx_data;
  end

  always_ff @(posedge i_s_axi_aclk or posedge i_s_axi_areset) begin
    if (i_s_axi_areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_tx_ovf <= 1'b0;
    end else if (i_fifo_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_tx_ovf <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (i_tx_valid && full) o_tx_ovf <= 1'b1;
    end
  end

  // Sanitised frame format, latched when a byte is popped.
  always_comb begin
    div_s     = (i_fre_cnt == 32'd0) ? 32'd1 : i_fre_cnt;
    nbits_s   = (i_uart_data_bit >= 4'd5 && i_uart_data_bit <= 4'd8) ? i_uart_data_bit : 4'd8;
    if (i_uart_stop_bit == 3'd0)     stop_s = 3'd1;
    else if (i_uart_stop_bit > 3'd4) stop_s = 3'd4;
    else                             stop_s = i_uart_stop_bit;
    head      = mem[rd_ptr];
    mask      = 8'hFF >> (4'd8 - nbits_s);
    par_en_s  = 1'b1;
    par_bit_s = 1'b0;
    case (i_uart_parity_mode)
      3'd1:    par_bit_s = ~^(head & mask);
      3'd2:    par_bit_s = ^(head & mask);
      3'd3:    par_bit_s = 1'b1;
      3'd4:    par_bit_s = 1'b0;
      default: par_en_s  = 1'b0;
    endcase
  end

  always_ff @(posedge i_s_axi_aclk or posedge i_s_axi_areset) begin
    if (i_s_axi_areset) begin
      state     <= IDLE;
      o_txd     <= 1'b1;
      o_tx_busy <= 1'b0;
      timer     <= '0;
      div_q     <= 32'd1;
      nbits_q   <= 4'd8;
      bit_cnt   <= '0;
      stop_rem  <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= START;
            o_txd     <= 1'b0;
            o_tx_busy <= 1'b1;
            timer     <= div_s - 32'd1;
            div_q     <= div_s;
            nbits_q   <= nbits_s;
            stop_rem  <= stop_s - 3'd1;
            par_en_q  <= par_en_s;
            par_bit_q <= par_bit_s;
            shreg     <= head;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            o_txd   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= 4'd1;
            timer   <= div_q - 32'd1;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        DATA: begin
          if (tick) begin
            timer <= div_q - 32'd1;
            if (bit_cnt == nbits_q) begin
              if (par_en_q) begin
                state <= PARITY;
                o_txd <= par_bit_q;
              end else begin
                state <= STOP;
                o_txd <= 1'b1;
              end
            end else begin
              o_txd   <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            timer <= timer - 32'd1;
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            o_txd <= 1'b1;
            timer <= div_q - 32'd1;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_rem == 3'd0) begin
              state     <= IDLE;
              o_tx_busy <= 1'b0;
              o_txd     <= 1'b1;
            end else begin
              stop_rem <= stop_rem - 3'd1;
              timer    <= div_q - 32'd1;
            end
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: begin
          state     <= IDLE;
          o_txd     <= 1'b1;
          o_tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a line monitor decodes every frame and checks it against expected bytes.
`timescale 1ns/1ps
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en = 1'b0;
  logic        fifo_clr = 1'b0;
  logic [31:0] fre_cnt = 32'd4;
  logic [3:0]  data_bit = 4'd8;
  logic [2:0]  parity_mode = 3'd0;
  logic [2:0]  stop_bit = 3'd1;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic [15:0] wr_cnt;
  logic        busy;
  logic        ovf;
  logic        txd;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_engine #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .i_s_axi_aclk      (clk),
    .i_s_axi_areset    (rst),
    .i_module_en       (module_en),
    .i_fifo_clr        (fifo_clr),
    .i_fre_cnt         (fre_cnt),
    .i_uart_data_bit   (data_bit),
    .i_uart_parity_mode(parity_mode),
    .i_uart_stop_bit   (stop_bit),
    .i_tx_data         (tx_data),
    .i_tx_valid        (tx_valid),
`ifdef UART_TX_CTS_EN
    .i_cts_n           (cts_n),
`endif
    .o_tx_fifo_wr_cnt  (wr_cnt),
    .o_tx_busy         (busy),
    .o_tx_ovf          (ovf),
    .o_txd             (txd)
  );

  int unsigned cyc = 0;
  int          busy_cycles = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          frames_done = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_cyc[$];

  // Effective frame format the monitor expects (derived by hand from the raw settings).
  int          m_div = 4;
  int          m_nbits = 8;
  int          m_stops = 1;
  logic [2:0]  m_par = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cycles <= busy_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] b, input int nb, input logic [2:0] mode);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(b[i]);
    case (mode)
      3'd1:    return (ones % 2 == 0);
      3'd2:    return (ones % 2 == 1);
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_cfg(input logic [31:0] f, input logic [3:0] d, input logic [2:0] p,
                         input logic [2:0] s, input int md, input int mn, input logic [2:0] mp,
                         input int ms);
    fre_cnt = f; data_bit = d; parity_mode = p; stop_bit = s;
    m_div = md; m_nbits = mn; m_par = mp; m_stops = ms;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic get_bit(input bit first, output logic v, output bit steady,
                         inout bit aborted, inout bit busy_ok);
    steady = 1'b1;
    v = 1'bx;
    for (int c = 0; c < m_div; c++) begin
      if (!(first && c == 0)) @(negedge clk);
      if (rst) begin
        aborted = 1'b1;
        return;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (c == 0) v = txd;
      else if (txd !== v) steady = 1'b0;
    end
  endtask

  initial begin : monitor
    logic       v;
    logic       par_got;
    bit         st;
    bit         steady_ok;
    bit         start_ok;
    bit         stop_ok;
    bit         aborted;
    bit         busy_ok;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic [7:0] mask;
    forever begin
      @(negedge clk);
      if (rst || txd !== 1'b0) continue;
      start_cyc.push_back(cyc);
      aborted = 0; busy_ok = 1; steady_ok = 1; stop_ok = 1; got = '0; par_got = 1'b0;
      get_bit(1'b1, v, st, aborted, busy_ok);
      start_ok = (v === 1'b0) && st;
      for (int i = 0; i < m_nbits; i++) begin
        if (!aborted) begin
          get_bit(1'b0, v, st, aborted, busy_ok);
          got[i] = v;
          steady_ok &= st;
        end
      end
      if (!aborted && m_par >= 3'd1 && m_par <= 3'd4) begin
        get_bit(1'b0, v, st, aborted, busy_ok);
        par_got = v;
        steady_ok &= st;
      end
      for (int s = 0; s < m_stops; s++) begin
        if (!aborted) begin
          get_bit(1'b0, v, st, aborted, busy_ok);
          stop_ok &= (v === 1'b1) && st;
        end
      end
      if (aborted) continue;
      @(negedge clk);
      check("gap_busy_low", 32'(busy), 32'd0);
      check("start_bit", 32'(start_ok), 32'd1);
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        mask  = 8'hFF >> (8 - m_nbits);
        check("data_bits", 32'(got), 32'(exp_b & mask));
        if (m_par >= 3'd1 && m_par <= 3'd4)
          check("parity_bit", 32'(par_got), 32'(exp_parity(exp_b, m_nbits, m_par)));
      end
      check("stop_bits", 32'(stop_ok), 32'd1);
      check("bit_steady", 32'(steady_ok), 32'd1);
      check("busy_in_frame", 32'(busy_ok), 32'd1);
      frames_done++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned wcyc;
    int          bc0;
    int          f0;
    logic [7:0]  b;

    repeat (2) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_count", 32'(wr_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 at 4 clocks/bit, latency from write to start bit
    module_en = 1'b1;
    set_cfg(32'd4, 4'd8, 3'd0, 3'd1, 4, 8, 3'd0, 1);
    start_cyc.delete();
    bc0 = busy_cycles; f0 = frames_done; wcyc = cyc;
    exp_q.push_back(8'h55);
    wr_byte(8'h55);
    check("lat_count_n1", 32'(wr_cnt), 32'd1);
    check("lat_txd_n1", 32'(txd), 32'd1);
    @(negedge clk);
    check("lat_txd_n2", 32'(txd), 32'd0);
    wait_frames(f0 + 1, 200);
    check("lat_start_cycle", start_cyc[0] - wcyc, 32'd2);
    check("busy_cycles_8n1", 32'(busy_cycles - bc0), 32'd40);

    // 7 data bits, odd parity, 2 stop bits; bit 7 must not appear
    set_cfg(32'd2, 4'd7, 3'd1, 3'd2, 2, 7, 3'd1, 2);
    bc0 = busy_cycles; f0 = frames_done;
    exp_q.push_back(8'hC1);
    wr_byte(8'hC1);
    wait_frames(f0 + 1, 200);
    check("busy_cycles_7o2", 32'(busy_cycles - bc0), 32'd22);

    // fill while disabled, overflow, then drain back-to-back
    module_en = 1'b0;
    set_cfg(32'd2, 4'd8, 3'd0, 3'd1, 2, 8, 3'd0, 1);
    start_cyc.delete();
    f0 = frames_done;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back(b);
      wr_byte(b);
    end
    check("fill_count", 32'(wr_cnt), 32'd16);
    check("fill_ovf", 32'(ovf), 32'd1);
    check("fill_txd_idle", 32'(txd), 32'd1);
    repeat (10) @(negedge clk);
    check("no_frame_disabled", 32'(frames_done), 32'(f0));
    module_en = 1'b1;
    wait_frames(f0 + 16, 16 * 25 + 50);
    check("drain_count", 32'(wr_cnt), 32'd0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < 16; i++)
      check("b2b_period", start_cyc[i] - start_cyc[i - 1], 32'd21);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // FIFO clear during a frame
    set_cfg(32'd4, 4'd8, 3'd0, 3'd1, 4, 8, 3'd0, 1);
    f0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 0) exp_q.push_back(b);
      wr_byte(b);
    end
    check("clr_pre_count", 32'(wr_cnt), 32'd5);
    repeat (5) @(negedge clk);
    fifo_clr = 1'b1;
    @(negedge clk);
    fifo_clr = 1'b0;
    check("clr_count", 32'(wr_cnt), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_busy_kept", 32'(busy), 32'd1);
    wait_frames(f0 + 1, 100);
    repeat (60) @(negedge clk);
    check("clr_no_more_frames", 32'(frames_done), 32'(f0 + 1));

    // out-of-range settings: divisor 1, 8 data bits, no parity, 1 stop
    set_cfg(32'd0, 4'd15, 3'd6, 3'd0, 1, 8, 3'd0, 1);
    bc0 = busy_cycles; f0 = frames_done;
    exp_q.push_back(8'hA7);
    wr_byte(8'hA7);
    wait_frames(f0 + 1, 100);
    check("busy_cycles_sanitised", 32'(busy_cycles - bc0), 32'd10);

`ifdef UART_TX_CTS_EN
    // CTS deasserted holds a queued byte; release starts it promptly
    set_cfg(32'd2, 4'd8, 3'd0, 3'd1, 2, 8, 3'd0, 1);
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    f0 = frames_done;
    exp_q.push_back(8'h3C);
    wr_byte(8'h3C);
    repeat (20) @(negedge clk);
    check("cts_hold_txd", 32'(txd), 32'd1);
    check("cts_hold_count", 32'(wr_cnt), 32'd1);
    cts_n = 1'b0;
    begin
      int n = 0;
      while (txd !== 1'b0 && n < 4) begin
        @(negedge clk);
        n++;
      end
    end
    check("cts_release_start", 32'(txd), 32'd0);
    wait_frames(f0 + 1, 100);
`endif

    // reset in the middle of the data bits
    set_cfg(32'd4, 4'd8, 3'd0, 3'd1, 4, 8, 3'd0, 1);
    f0 = frames_done;
    wr_byte(8'($urandom_range(0, 255)));
    wr_byte(8'($urandom_range(0, 255)));
    repeat (8) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(wr_cnt), 32'd0);
    check("post_rst_ovf", 32'(ovf), 32'd0);
    repeat (20) @(negedge clk);
    check("post_rst_idle_txd", 32'(txd), 32'd1);
    check("post_rst_no_frame", 32'(frames_done), 32'(f0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
